uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive half of the inter-board UART link, directly downstream of the transmitter on the serial line.
- Oversamples the rx pin on the system clock and recovers frames of start(0), 8 data bits LSB first, parity, stop(1).
- Presents each received byte with a one-cycle valid strobe plus parity and framing error flags.
- Same line format, parity convention and baud plan as the transmitter: 8 Mbaud at 24 MHz, 3 clocks per bit.

Parameters:
- CLKS_PER_BIT, 3, system clocks per bit period; minimum 3.
- PARITY, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = inverted XOR of data).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-clock pulse when a frame completes.
- parity_err  output  1  parity mismatch on the last frame; valid with rx_valid, held until the next rx_valid.
- frame_err  output  1  stop bit sampled 0 on the last frame; valid with rx_valid, held until the next rx_valid.
- rx_busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-low.
  - While reset=0 at a clk edge: state=IDLE, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Synchronizer flops and the armed flag are set to 1; counters are set to 0.
  - Reset mid-frame discards the partial frame and produces no rx_valid.
- Synchronizer:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s only.
- Timing notation:
  - N = CLKS_PER_BIT, H = N/2 (integer division).
  - Cycle 0 is the first cycle rx_s=0 while in IDLE and armed.
- States:
  - IDLE:
    - armed is set when rx_s=1.
    - When armed and rx_s=0: clear the bit counter, set the cycle counter to 0, go to START.
  - START: at cycle H, sample rx_s.
    - rx_s=1: false start; return to IDLE with no output.
    - rx_s=0: go to DATA.
  - DATA:
    - Data bit i (0..7) is sampled at cycle H+(i+1)*N.
    - Each sample shifts in from the MSB side, so bit 0 ends in rx_data[0].
    - After bit 7, go to PARITY.
  - PARITY:
    - Sampled at H+9N.
    - Compare with the expected parity computed from the 8 received data bits per PARITY.
  - STOP:
    - Sampled at H+10N.
    - On the next edge (cycle H+10N+1): rx_data=byte; parity_err and frame_err updated; rx_valid=1 for exactly one cycle; go to IDLE.
    - armed is cleared; the next start edge needs rx_s=1 first, so a held-low line (break) yields exactly one frame with frame_err=1.
- Cycle counter:
  - Width ceil(log2(11*N+1)).
  - Never wraps within a frame.
- Error handling:
  - rx_data is updated even when a flag is set.
  - No backpressure: a new frame overwrites rx_data.
  - Consumers must take the byte in the rx_valid cycle.
- Latency:
  - From the pin start edge to rx_valid is 2 + H+10N+1 clocks.
  - For N=3 this is 34 clocks.
- Back-to-back frames: a start bit arriving immediately after the stop bit (stop bit exactly 1 bit long) is received without loss.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_s at sample cycle-1, cycle and cycle+1.
  - The decision is taken at sample cycle+1; all downstream timing shifts by one clock, giving rx_valid at H+10N+2.
  - A single-cycle glitch at the start edge that is not confirmed by the majority aborts to IDLE.
- Undefined: single sample at the mid-bit cycle as described above.

Test Plan:
- Reset, then frame 0xA5 with even parity bit 0 and stop 1, N=3 -> one rx_valid pulse 34 clocks after the start edge; rx_data=0xA5, parity_err=0, frame_err=0; rx_busy low again the cycle after.
- Frame 0x3C with the parity bit forced to 1 -> rx_valid, rx_data=0x3C, parity_err=1. Repeat with PARITY=1 and parity bit 1 -> parity_err=0.
- Frame 0x00 with stop bit 0 and the line then held low for 40 clocks -> exactly one rx_valid with frame_err=1. After the line returns high, frame 0x55 -> rx_valid, frame_err=0.
- Line pulsed low for 1 clock, then high -> no rx_valid; the module returns to IDLE by cycle H+1. A valid frame 0x81 immediately after is received correctly.
- Frames 0x01, 0xFF, 0x7E sent back-to-back with no idle gap -> three rx_valid pulses spaced 33 clocks apart (11*N) with correct data, no errors.
- reset driven low at data bit 4 of frame 0xF0, then released -> no rx_valid and all outputs 0. A following frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: receive half of the inter-board UART link.
// Frame format: start(0), 8 data bits LSB first, parity, stop(1).
// Each bit is CLKS_PER_BIT system clocks long. The rx pin is synchronised
// and then sampled once per bit near mid-bit.
// Optional macro UART_RX_MAJORITY_EN: each bit is taken as a 2-of-3 majority
// vote around the mid-bit sample. The decision lands one clock later, so
// every timing point moves by one clock.
module uart_rx #(
  parameter int CLKS_PER_BIT = 3,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int N     = CLKS_PER_BIT;
  localparam int H     = N / 2;
  localparam int CNT_W = $clog2(11 * N + 1);

  localparam logic [CNT_W-1:0] H_C   = CNT_W'(H);
  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic             PAR_ODD = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;

  logic             bit_val;
  logic             sample_now;
  logic             arm_after_stop;

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1_q, rx_h2_q;

  // Two-deep history of the synchronised line, used for the majority vote
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_s_q;
      rx_h2_q <= rx_h1_q;
    end
  end

  // The vote covers samples at mid-bit-1, mid-bit and mid-bit+1. It is taken
  // one clock after mid-bit. Rearming from the live line at the stop decision
  // keeps back-to-back frames intact despite the extra clock of delay.
  assign bit_val        = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
  assign sample_now     = (cnt_q == samp_q + ONE_C);
  assign arm_after_stop = rx_s_q;
`else
  // Single mid-bit sample. After a frame the line must be seen high before
  // another start edge is accepted.
  assign bit_val        = rx_s_q;
  assign sample_now     = (cnt_q == samp_q);
  assign arm_after_stop = 1'b0;
`endif

  // Next-state logic: frame sequencing, bit capture and result latching
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    samp_d       = samp_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + ONE_C;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // This cycle is cycle 0, so the first cycle in START is cycle 1
          state_d   = ST_START;
          cnt_d     = ONE_C;
          samp_d    = H_C;
          bit_cnt_d = 3'd0;
        end
      end
      ST_START: begin
        if (sample_now) begin
          if (bit_val) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            samp_d  = samp_q + N_C;
          end
        end
      end
      ST_DATA: begin
        if (sample_now) begin
          shift_d = {bit_val, shift_q[7:1]};
          samp_d  = samp_q + N_C;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample_now) begin
          par_bit_d = bit_val;
          samp_d    = samp_q + N_C;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_now) begin
          rx_data_d    = shift_q;
          parity_err_d = par_bit_q ^ (^shift_q) ^ PAR_ODD;
          frame_err_d  = ~bit_val;
          rx_valid_d   = 1'b1;
          armed_d      = arm_after_stop;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers and the 2-flop synchroniser on the rx pin
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      armed_q      <= 1'b1;
      cnt_q        <= '0;
      samp_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      samp_q       <= samp_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLKS_PER_BIT=3.
// An even-parity and an odd-parity instance share the same serial line.
module tb_uart_rx;

  localparam int N = 3;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;
  logic [7:0] odd_rx_data;
  logic       odd_rx_valid;
  logic       odd_parity_err;
  logic       odd_frame_err;
  logic       odd_rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } vrec_t;

  vrec_t vq[$];
  vrec_t oq[$];
  logic  busy_hist [0:8191];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_odd_perr;
  } vec_t;

  vec_t vecs [5];

  uart_rx #(.CLKS_PER_BIT(N), .PARITY(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  uart_rx #(.CLKS_PER_BIT(N), .PARITY(1)) dut_odd (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (odd_rx_data),
    .rx_valid   (odd_rx_valid),
    .parity_err (odd_parity_err),
    .frame_err  (odd_frame_err),
    .rx_busy    (odd_rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse and the busy flag, sampled on the falling edge
  always @(negedge clk) begin : monitor
    vrec_t r;
    if (cyc < 8192) busy_hist[cyc] = rx_busy;
    if (rx_valid === 1'b1) begin
      r.cyc = cyc; r.data = rx_data; r.perr = parity_err; r.ferr = frame_err; r.busy = rx_busy;
      vq.push_back(r);
    end
    if (odd_rx_valid === 1'b1) begin
      r.cyc = cyc; r.data = odd_rx_data; r.perr = odd_parity_err; r.ferr = odd_frame_err; r.busy = odd_rx_busy;
      oq.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame (start, data LSB first, parity, stop).
  // Entry and exit are both 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                               input int nbits, output int start_cyc);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (N) @(posedge clk);
      #1;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " rx_data"},    32'(rx_data),    32'h0);
    checkOutput({tag, " rx_valid"},   32'(rx_valid),   32'h0);
    checkOutput({tag, " parity_err"}, 32'(parity_err), 32'h0);
    checkOutput({tag, " frame_err"},  32'(frame_err),  32'h0);
    checkOutput({tag, " rx_busy"},    32'(rx_busy),    32'h0);
  endtask

  initial begin
    int s, s0, g;

    // Directed single frames and their expected results for both parity modes
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    rx    = 1'b1;
    idle(4);
    checkIdleOutputs("reset");
    reset = 1'b1;
    idle(5);

    for (int v = 0; v < 5; v++) begin
      vq.delete();
      oq.delete();
      applyStimulus(vecs[v].data, vecs[v].par, vecs[v].stop, 11, s);
      rx = 1'b1;
      idle(12);
      checkOutput($sformatf("vec%0d count", v), 32'(vq.size()), 32'd1);
      checkOutput($sformatf("vec%0d odd count", v), 32'(oq.size()), 32'd1);
      if (vq.size() >= 1) begin
        checkOutput($sformatf("vec%0d latency", v), 32'(vq[0].cyc - s), 32'd34);
        checkOutput($sformatf("vec%0d data", v), 32'(vq[0].data), 32'(vecs[v].data));
        checkOutput($sformatf("vec%0d parity_err", v), 32'(vq[0].perr), 32'(vecs[v].exp_perr));
        checkOutput($sformatf("vec%0d frame_err", v), 32'(vq[0].ferr), 32'(vecs[v].exp_ferr));
      end
      if (oq.size() >= 1) begin
        checkOutput($sformatf("vec%0d odd data", v), 32'(oq[0].data), 32'(vecs[v].data));
        checkOutput($sformatf("vec%0d odd parity_err", v), 32'(oq[0].perr), 32'(vecs[v].exp_odd_perr));
      end
      checkOutput($sformatf("vec%0d busy mid-frame", v), 32'(busy_hist[s + 10]), 32'd1);
      checkOutput($sformatf("vec%0d busy after valid", v), 32'(busy_hist[s + 35]), 32'd0);
    end

    // Break: stop bit 0 and the line held low gives exactly one frame
    vq.delete();
    applyStimulus(8'h00, 1'b0, 1'b0, 11, s);
    idle(40);
    rx = 1'b1;
    idle(10);
    checkOutput("break count", 32'(vq.size()), 32'd1);
    if (vq.size() >= 1) begin
      checkOutput("break latency", 32'(vq[0].cyc - s), 32'd34);
      checkOutput("break data", 32'(vq[0].data), 32'h00);
      checkOutput("break frame_err", 32'(vq[0].ferr), 32'd1);
      checkOutput("break parity_err", 32'(vq[0].perr), 32'd0);
    end
    vq.delete();
    applyStimulus(8'h55, 1'b0, 1'b1, 11, s);
    idle(12);
    checkOutput("post-break count", 32'(vq.size()), 32'd1);
    if (vq.size() >= 1) begin
      checkOutput("post-break data", 32'(vq[0].data), 32'h55);
      checkOutput("post-break frame_err", 32'(vq[0].ferr), 32'd0);
    end

    // One-clock glitch: false start, back in IDLE by cycle H+1, then a real frame
    vq.delete();
    g = cyc;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(2);
    applyStimulus(8'h81, 1'b0, 1'b1, 11, s);
    idle(12);
    checkOutput("glitch busy in START", 32'(busy_hist[g + 3]), 32'd1);
    checkOutput("glitch busy back idle", 32'(busy_hist[g + 4]), 32'd0);
    checkOutput("glitch count", 32'(vq.size()), 32'd1);
    if (vq.size() >= 1) begin
      checkOutput("glitch frame latency", 32'(vq[0].cyc - s), 32'd34);
      checkOutput("glitch frame data", 32'(vq[0].data), 32'h81);
      checkOutput("glitch frame parity_err", 32'(vq[0].perr), 32'd0);
    end

    // Back-to-back frames with no idle gap
    vq.delete();
    applyStimulus(8'h01, 1'b1, 1'b1, 11, s0);
    applyStimulus(8'hFF, 1'b0, 1'b1, 11, s);
    applyStimulus(8'h7E, 1'b0, 1'b1, 11, s);
    idle(12);
    checkOutput("b2b count", 32'(vq.size()), 32'd3);
    if (vq.size() >= 3) begin
      checkOutput("b2b first latency", 32'(vq[0].cyc - s0), 32'd34);
      checkOutput("b2b spacing 1", 32'(vq[1].cyc - vq[0].cyc), 32'd33);
      checkOutput("b2b spacing 2", 32'(vq[2].cyc - vq[1].cyc), 32'd33);
      checkOutput("b2b data 0", 32'(vq[0].data), 32'h01);
      checkOutput("b2b data 1", 32'(vq[1].data), 32'hFF);
      checkOutput("b2b data 2", 32'(vq[2].data), 32'h7E);
      checkOutput("b2b errs", 32'({vq[0].perr, vq[0].ferr, vq[1].perr, vq[1].ferr, vq[2].perr, vq[2].ferr}), 32'h0);
    end

    // Reset at data bit 4 discards the frame and clears outputs
    vq.delete();
    applyStimulus(8'hF0, 1'b0, 1'b1, 5, s);
    reset = 1'b0;
    rx    = 1'b1;
    idle(3);
    checkIdleOutputs("mid-frame reset");
    reset = 1'b1;
    idle(40);
    checkOutput("mid-frame reset no valid", 32'(vq.size()), 32'd0);
    applyStimulus(8'h0F, 1'b0, 1'b1, 11, s);
    idle(12);
    checkOutput("post-reset count", 32'(vq.size()), 32'd1);
    if (vq.size() >= 1) begin
      checkOutput("post-reset latency", 32'(vq[0].cyc - s), 32'd34);
      checkOutput("post-reset data", 32'(vq[0].data), 32'h0F);
      checkOutput("post-reset errs", 32'({vq[0].perr, vq[0].ferr}), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
